// File: rtl/accelerator_state_vector_scheduler.sv
// accelerator_state_vector_scheduler
// Sequences x(k+1) = A*x(k) + B*u(k) for k = 0..K-1 on one shared
// multiply-accumulate datapath. Operands are fetched one at a time over a
// request/acknowledge port; each finished x(k+1)[i] is streamed out.
module accelerator_state_vector_scheduler #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64,
    parameter int MAX_SIZE     = 8,
    parameter int INDEX_SIZE   = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    output logic                    ERROR,
    input  logic [CONTROL_SIZE-1:0] SIZE_N_IN,
    input  logic [CONTROL_SIZE-1:0] SIZE_M_IN,
    input  logic [CONTROL_SIZE-1:0] STEPS_IN,
    input  logic                    DATA_X_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]    DATA_X_IN,
    output logic                    OPERAND_REQ,
    output logic [1:0]              OPERAND_SEL,
    output logic [INDEX_SIZE-1:0]   OPERAND_I,
    output logic [INDEX_SIZE-1:0]   OPERAND_J,
    output logic [CONTROL_SIZE-1:0] OPERAND_K,
    input  logic                    OPERAND_ACK,
    input  logic [DATA_SIZE-1:0]    OPERAND_IN,
    output logic                    DATA_X_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]    DATA_X_OUT,
    output logic [INDEX_SIZE-1:0]   DATA_X_OUT_I
);

    localparam int ADDR_W = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_U = 2'd2;

    localparam logic [INDEX_SIZE-1:0]   IDX_ZERO  = {INDEX_SIZE{1'b0}};
    localparam logic [INDEX_SIZE-1:0]   IDX_ONE   = {{(INDEX_SIZE-1){1'b0}}, 1'b1};
    localparam logic [CONTROL_SIZE-1:0] CTL_ZERO  = {CONTROL_SIZE{1'b0}};
    localparam logic [CONTROL_SIZE-1:0] CTL_ONE   = {{(CONTROL_SIZE-1){1'b0}}, 1'b1};
    localparam logic [CONTROL_SIZE-1:0] CTL_MAX   = CONTROL_SIZE'(MAX_SIZE);
    localparam logic [DATA_SIZE-1:0]    DATA_ZERO = {DATA_SIZE{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_X  = 3'd1,
        ST_FETCH_U = 3'd2,
        ST_ROW_A   = 3'd3,
        ST_ROW_B   = 3'd4,
        ST_WRITE   = 3'd5,
        ST_COMMIT  = 3'd6
    } state_t;

    // Registered state
    state_t                  state_r;
    logic [INDEX_SIZE-1:0]   n_r, m_r, i_r, j_r, idx_r, out_i_r;
    logic [CONTROL_SIZE-1:0] steps_r, k_r;
    logic [DATA_SIZE-1:0]    acc_r, out_data_r;
    logic                    req_r, ready_r, error_r, out_en_r;
    logic [1:0]              sel_r;
    logic [DATA_SIZE-1:0]    x_r  [MAX_SIZE];
    logic [DATA_SIZE-1:0]    xn_r [MAX_SIZE];
    logic [DATA_SIZE-1:0]    u_r  [MAX_SIZE];

    // Next-state values
    state_t                  state_s;
    logic [INDEX_SIZE-1:0]   n_s, m_s, i_s, j_s, idx_s, out_i_s;
    logic [CONTROL_SIZE-1:0] steps_s, k_s;
    logic [DATA_SIZE-1:0]    acc_s, out_data_s;
    logic                    req_s, ready_s, error_s, out_en_s;
    logic [1:0]              sel_s;
    logic                    x_load_we_s, u_we_s, xn_we_s, commit_s;

    // Datapath helpers
    logic                    start_bad_s, xfer_s;
    logic [INDEX_SIZE-1:0]   n_last_s, m_last_s;
    logic [ADDR_W-1:0]       j_addr_s, i_addr_s, idx_addr_s;
    logic [DATA_SIZE-1:0]    mul_s, prod_s, acc_sum_s;

    assign start_bad_s = (SIZE_N_IN == CTL_ZERO) || (SIZE_N_IN > CTL_MAX) ||
                         (SIZE_M_IN > CTL_MAX)   || (STEPS_IN == CTL_ZERO);
    assign xfer_s      = req_r & OPERAND_ACK;
    assign n_last_s    = n_r - IDX_ONE;
    assign m_last_s    = m_r - IDX_ONE;
    assign j_addr_s    = j_r[ADDR_W-1:0];
    assign i_addr_s    = i_r[ADDR_W-1:0];
    assign idx_addr_s  = idx_r[ADDR_W-1:0];
    // Low DATA_SIZE bits of the product are identical for signed and unsigned.
    assign prod_s      = OPERAND_IN * mul_s;
    assign acc_sum_s   = acc_r + prod_s;

    // Pick the vector element that multiplies the incoming A or B operand.
    always_comb begin
        mul_s = x_r[j_addr_s];
        if (state_r == ST_ROW_B) begin
            mul_s = u_r[j_addr_s];
        end else begin
            mul_s = x_r[j_addr_s];
        end
    end

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_s     = state_r;
        n_s         = n_r;
        m_s         = m_r;
        steps_s     = steps_r;
        k_s         = k_r;
        i_s         = i_r;
        j_s         = j_r;
        idx_s       = idx_r;
        acc_s       = acc_r;
        req_s       = req_r;
        sel_s       = sel_r;
        ready_s     = 1'b0;
        error_s     = error_r;
        out_en_s    = 1'b0;
        out_data_s  = out_data_r;
        out_i_s     = out_i_r;
        x_load_we_s = 1'b0;
        u_we_s      = 1'b0;
        xn_we_s     = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                req_s = 1'b0;
                if (START) begin
                    n_s     = SIZE_N_IN[INDEX_SIZE-1:0];
                    m_s     = SIZE_M_IN[INDEX_SIZE-1:0];
                    steps_s = STEPS_IN;
                    if (start_bad_s) begin
                        error_s = 1'b1;
                        ready_s = 1'b1;
                    end else begin
                        error_s = 1'b0;
                        k_s     = CTL_ZERO;
                        i_s     = IDX_ZERO;
                        j_s     = IDX_ZERO;
                        idx_s   = IDX_ZERO;
                        state_s = ST_LOAD_X;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD_X: begin
                if (DATA_X_IN_ENABLE) begin
                    x_load_we_s = 1'b1;
                    if (idx_r == n_last_s) begin
                        idx_s = IDX_ZERO;
                        req_s = 1'b1;
                        j_s   = IDX_ZERO;
                        if (m_r == IDX_ZERO) begin
                            state_s = ST_ROW_A;
                            sel_s   = SEL_A;
                            acc_s   = DATA_ZERO;
                        end else begin
                            state_s = ST_FETCH_U;
                            sel_s   = SEL_U;
                        end
                    end else begin
                        idx_s = idx_r + IDX_ONE;
                    end
                end else begin
                    state_s = ST_LOAD_X;
                end
            end
            ST_FETCH_U: begin
                if (xfer_s) begin
                    u_we_s = 1'b1;
                    if (j_r == m_last_s) begin
                        state_s = ST_ROW_A;
                        sel_s   = SEL_A;
                        j_s     = IDX_ZERO;
                        acc_s   = DATA_ZERO;
                    end else begin
                        j_s = j_r + IDX_ONE;
                    end
                end else begin
                    state_s = ST_FETCH_U;
                end
            end
            ST_ROW_A: begin
                if (xfer_s) begin
                    acc_s = acc_sum_s;
                    if (j_r == n_last_s) begin
                        j_s = IDX_ZERO;
                        if (m_r == IDX_ZERO) begin
                            state_s    = ST_WRITE;
                            req_s      = 1'b0;
                            xn_we_s    = 1'b1;
                            out_en_s   = 1'b1;
                            out_data_s = acc_sum_s;
                            out_i_s    = i_r;
                        end else begin
                            state_s = ST_ROW_B;
                            sel_s   = SEL_B;
                        end
                    end else begin
                        j_s = j_r + IDX_ONE;
                    end
                end else begin
                    state_s = ST_ROW_A;
                end
            end
            ST_ROW_B: begin
                if (xfer_s) begin
                    acc_s = acc_sum_s;
                    if (j_r == m_last_s) begin
                        j_s        = IDX_ZERO;
                        state_s    = ST_WRITE;
                        req_s      = 1'b0;
                        xn_we_s    = 1'b1;
                        out_en_s   = 1'b1;
                        out_data_s = acc_sum_s;
                        out_i_s    = i_r;
                    end else begin
                        j_s = j_r + IDX_ONE;
                    end
                end else begin
                    state_s = ST_ROW_B;
                end
            end
            ST_WRITE: begin
                if (i_r == n_last_s) begin
                    state_s = ST_COMMIT;
                end else begin
                    i_s     = i_r + IDX_ONE;
                    state_s = ST_ROW_A;
                    req_s   = 1'b1;
                    sel_s   = SEL_A;
                    j_s     = IDX_ZERO;
                    acc_s   = DATA_ZERO;
                end
            end
            ST_COMMIT: begin
                commit_s = 1'b1;
                k_s      = k_r + CTL_ONE;
                i_s      = IDX_ZERO;
                j_s      = IDX_ZERO;
                if ((k_r + CTL_ONE) == steps_r) begin
                    state_s = ST_IDLE;
                    ready_s = 1'b1;
                end else if (m_r == IDX_ZERO) begin
                    state_s = ST_ROW_A;
                    req_s   = 1'b1;
                    sel_s   = SEL_A;
                    acc_s   = DATA_ZERO;
                end else begin
                    state_s = ST_FETCH_U;
                    req_s   = 1'b1;
                    sel_s   = SEL_U;
                end
            end
            default: begin
                state_s = ST_IDLE;
                req_s   = 1'b0;
            end
        endcase
    end

    // Control registers and registered outputs; reset aborts any run silently.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            n_r        <= IDX_ZERO;
            m_r        <= IDX_ZERO;
            steps_r    <= CTL_ZERO;
            k_r        <= CTL_ZERO;
            i_r        <= IDX_ZERO;
            j_r        <= IDX_ZERO;
            idx_r      <= IDX_ZERO;
            acc_r      <= DATA_ZERO;
            req_r      <= 1'b0;
            sel_r      <= SEL_A;
            ready_r    <= 1'b0;
            error_r    <= 1'b0;
            out_en_r   <= 1'b0;
            out_data_r <= DATA_ZERO;
            out_i_r    <= IDX_ZERO;
        end else begin
            state_r    <= state_s;
            n_r        <= n_s;
            m_r        <= m_s;
            steps_r    <= steps_s;
            k_r        <= k_s;
            i_r        <= i_s;
            j_r        <= j_s;
            idx_r      <= idx_s;
            acc_r      <= acc_s;
            req_r      <= req_s;
            sel_r      <= sel_s;
            ready_r    <= ready_s;
            error_r    <= error_s;
            out_en_r   <= out_en_s;
            out_data_r <= out_data_s;
            out_i_r    <= out_i_s;
        end
    end

    // Vector buffers: x(k) is only replaced at commit, so all rows of a step see x(k).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int e = 0; e < MAX_SIZE; e++) begin
                x_r[e]  <= DATA_ZERO;
                xn_r[e] <= DATA_ZERO;
                u_r[e]  <= DATA_ZERO;
            end
        end else begin
            if (x_load_we_s) begin
                x_r[idx_addr_s] <= DATA_X_IN;
            end else if (commit_s) begin
                for (int e = 0; e < MAX_SIZE; e++) begin
                    x_r[e] <= xn_r[e];
                end
            end
            if (u_we_s) begin
                u_r[j_addr_s] <= OPERAND_IN;
            end
            if (xn_we_s) begin
                xn_r[i_addr_s] <= acc_sum_s;
            end
        end
    end

    assign READY             = ready_r;
    assign ERROR             = error_r;
    assign OPERAND_REQ       = req_r;
    assign OPERAND_SEL       = sel_r;
    assign OPERAND_I         = i_r;
    assign OPERAND_J         = j_r;
    assign OPERAND_K         = k_r;
    assign DATA_X_OUT_ENABLE = out_en_r;
    assign DATA_X_OUT        = out_data_r;
    assign DATA_X_OUT_I      = out_i_r;

endmodule

// File: tb/tb_accelerator_state_vector_scheduler.sv
// Self-checking bench for accelerator_state_vector_scheduler: a randomized
// operand responder plus a matrix-arithmetic reference of x(k+1) = A x + B u.
module tb_accelerator_state_vector_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ready, error;
    logic [63:0] size_n = 64'd0, size_m = 64'd0, steps = 64'd0;
    logic        x_en = 1'b0;
    logic [63:0] x_in = 64'd0;
    logic        req;
    logic [1:0]  sel;
    logic [3:0]  op_i, op_j;
    logic [63:0] op_k;
    logic        ack = 1'b0;
    logic [63:0] operand_in = 64'd0;
    logic        out_en;
    logic [63:0] out_data;
    logic [3:0]  out_i;
    logic [145:0] all_outs;

    accelerator_state_vector_scheduler dut (
        .CLK(clk), .RST(rst), .START(start), .READY(ready), .ERROR(error),
        .SIZE_N_IN(size_n), .SIZE_M_IN(size_m), .STEPS_IN(steps),
        .DATA_X_IN_ENABLE(x_en), .DATA_X_IN(x_in),
        .OPERAND_REQ(req), .OPERAND_SEL(sel), .OPERAND_I(op_i), .OPERAND_J(op_j),
        .OPERAND_K(op_k), .OPERAND_ACK(ack), .OPERAND_IN(operand_in),
        .DATA_X_OUT_ENABLE(out_en), .DATA_X_OUT(out_data), .DATA_X_OUT_I(out_i)
    );

    assign all_outs = {ready, error, req, sel, op_i, op_j, op_k, out_en, out_data, out_i};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // Scenario data and reference results
    logic [63:0] a_tab [8][8];
    logic [63:0] b_tab [8][8];
    logic [63:0] u_tab [4][8];
    logic [63:0] x0_tab [8];
    logic [63:0] exp_val [$];
    int          exp_i [$];
    logic [63:0] got_val [$];
    int          got_i [$];

    int n_cur = 0, m_cur = 0, k_cur = 0;
    int max_delay = 0;
    int sel_cnt [4];
    int ready_cnt = 0, req_seen = 0;
    int last_xfer_cyc = -10, last_strobe_cyc = -10;
    bit strobe_seen = 1'b0;

    // Reference: plain matrix-vector arithmetic modulo 2^64.
    function automatic void build_model(input int n, input int m, input int kk);
        logic [63:0] xs [8];
        logic [63:0] xn [8];
        logic [63:0] s;
        exp_val.delete();
        exp_i.delete();
        for (int e = 0; e < 8; e++) xs[e] = x0_tab[e];
        for (int k = 0; k < kk; k++) begin
            for (int i = 0; i < n; i++) begin
                s = 64'd0;
                for (int j = 0; j < n; j++) s = s + a_tab[i][j] * xs[j];
                for (int j = 0; j < m; j++) s = s + b_tab[i][j] * u_tab[k][j];
                xn[i] = s;
                exp_val.push_back(s);
                exp_i.push_back(i);
            end
            for (int e = 0; e < n; e++) xs[e] = xn[e];
        end
    endfunction

    // Operand responder and output monitor, evaluated mid-cycle.
    initial begin
        int  wait_left;
        bit  pending;
        bit  stall_prev;
        logic [1:0]  p_sel;
        logic [3:0]  p_i, p_j;
        logic [63:0] p_k;
        int  oi, oj, ok;
        bit  addr_ok;
        pending = 1'b0;
        stall_prev = 1'b0;
        wait_left = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ack = 1'b0;
                pending = 1'b0;
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    total++;
                    if (req !== 1'b1 || sel !== p_sel || op_i !== p_i || op_j !== p_j || op_k !== p_k) begin
                        bad++;
                        $display("FAIL addr_stable: got req=%0b sel=%0d i=%0d j=%0d k=%0d, required req=1 sel=%0d i=%0d j=%0d k=%0d",
                                 req, sel, op_i, op_j, op_k, p_sel, p_i, p_j, p_k);
                    end
                end
                stall_prev = 1'b0;
                if (req === 1'b1) begin
                    if (!pending) begin
                        wait_left = $urandom_range(0, max_delay);
                        pending = 1'b1;
                    end
                    if (wait_left == 0) begin
                        oi = int'(op_i);
                        oj = int'(op_j);
                        ok = (op_k < 64'd4) ? int'(op_k) : 99;
                        case (sel)
                            2'd0: addr_ok = (oi < n_cur) && (oj < n_cur) && (ok < k_cur);
                            2'd1: addr_ok = (oi < n_cur) && (oj < m_cur) && (ok < k_cur);
                            2'd2: addr_ok = (oi == 0) && (oj < m_cur) && (ok < k_cur);
                            default: addr_ok = 1'b0;
                        endcase
                        total++;
                        if (addr_ok !== 1'b1) begin
                            bad++;
                            $display("FAIL operand_addr: got sel=%0d i=%0d j=%0d k=%0d, required in range n=%0d m=%0d K=%0d",
                                     sel, op_i, op_j, op_k, n_cur, m_cur, k_cur);
                            operand_in = 64'd0;
                        end else if (sel == 2'd0) begin
                            operand_in = a_tab[oi][oj];
                        end else if (sel == 2'd1) begin
                            operand_in = b_tab[oi][oj];
                        end else begin
                            operand_in = u_tab[ok][oj];
                        end
                        ack = 1'b1;
                        pending = 1'b0;
                        last_xfer_cyc = cyc;
                        sel_cnt[sel]++;
                    end else begin
                        ack = 1'b0;
                        operand_in = {$urandom, $urandom};
                        wait_left--;
                        stall_prev = 1'b1;
                        p_sel = sel; p_i = op_i; p_j = op_j; p_k = op_k;
                    end
                    req_seen++;
                end else begin
                    ack = 1'($urandom_range(0, 1));
                    operand_in = {$urandom, $urandom};
                    pending = 1'b0;
                end
                if (out_en === 1'b1) begin
                    got_val.push_back(out_data);
                    got_i.push_back(int'(out_i));
                    total++;
                    if (cyc != last_xfer_cyc + 1) begin
                        bad++;
                        $display("FAIL strobe_latency: got strobe at cycle %0d, required %0d", cyc, last_xfer_cyc + 1);
                    end
                    last_strobe_cyc = cyc;
                    strobe_seen = 1'b1;
                end
                if (ready === 1'b1) begin
                    ready_cnt++;
                    if (strobe_seen) begin
                        total++;
                        if (cyc != last_strobe_cyc + 2) begin
                            bad++;
                            $display("FAIL ready_latency: got READY at cycle %0d, required %0d", cyc, last_strobe_cyc + 2);
                        end
                    end
                end
            end
        end
    end

    task automatic start_and_load(input int n, input int m, input int kk);
        n_cur = n; m_cur = m; k_cur = kk;
        got_val.delete();
        got_i.delete();
        for (int s = 0; s < 4; s++) sel_cnt[s] = 0;
        ready_cnt = 0;
        req_seen = 0;
        strobe_seen = 1'b0;
        build_model(n, m, kk);
        @(negedge clk);
        start = 1'b1;
        size_n = 64'(n); size_m = 64'(m); steps = 64'(kk);
        @(negedge clk);
        start = 1'b0;
        total++;
        if (error !== 1'b0) begin
            bad++;
            $display("FAIL error_cleared: got ERROR=%0b, required 0", error);
        end
        for (int idx = 0; idx < n; idx++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            x_en = 1'b1;
            x_in = x0_tab[idx];
            @(negedge clk);
            x_en = 1'b0;
            x_in = {$urandom, $urandom};
        end
    endtask

    task automatic finish_run(input string name);
        int budget;
        budget = 20000;
        while (ready_cnt == 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        total++;
        if (budget == 0) begin
            bad++;
            $display("FAIL %s ready_timeout: got no READY, required READY", name);
        end
        repeat (3) @(negedge clk);
        total++;
        if (ready_cnt !== 1) begin
            bad++;
            $display("FAIL %s ready_count: got %0d, required 1", name, ready_cnt);
        end
        total++;
        if (got_val.size() !== exp_val.size()) begin
            bad++;
            $display("FAIL %s out_count: got %0d, required %0d", name, got_val.size(), exp_val.size());
        end
        for (int e = 0; e < exp_val.size() && e < got_val.size(); e++) begin
            total++;
            if (got_val[e] !== exp_val[e] || got_i[e] !== exp_i[e]) begin
                bad++;
                $display("FAIL %s out[%0d]: got i=%0d x=%0h, required i=%0d x=%0h",
                         name, e, got_i[e], got_val[e], exp_i[e], exp_val[e]);
            end
        end
        total++;
        if (error !== 1'b0) begin
            bad++;
            $display("FAIL %s error_after_run: got %0b, required 0", name, error);
        end
    endtask

    task automatic load_case1();
        for (int i = 0; i < 8; i++) begin
            x0_tab[i] = 64'd0;
            for (int j = 0; j < 8; j++) begin
                a_tab[i][j] = 64'd0;
                b_tab[i][j] = 64'd0;
            end
            for (int k = 0; k < 4; k++) u_tab[k][i] = 64'd0;
        end
        x0_tab[0] = 64'd1; x0_tab[1] = 64'd1;
        u_tab[0][0] = 64'd5;
        a_tab[0][0] = 64'd1; a_tab[0][1] = 64'd2;
        a_tab[1][0] = 64'd3; a_tab[1][1] = 64'd4;
        b_tab[0][0] = 64'd1; b_tab[1][0] = 64'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (all_outs !== {146{1'b0}}) begin
            bad++;
            $display("FAIL reset_outputs: got %0h, required 0", all_outs);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (all_outs !== {146{1'b0}}) begin
            bad++;
            $display("FAIL idle_outputs: got %0h, required 0", all_outs);
        end
    endtask

    task automatic test_basic();
        load_case1();
        max_delay = 0;
        start_and_load(2, 1, 1);
        finish_run("basic");
        total++;
        if (exp_val.size() != 2 || exp_val[0] !== 64'd8 || exp_val[1] !== 64'd12 ||
            got_val.size() != 2 || got_val[0] !== 64'd8 || got_val[1] !== 64'd12) begin
            bad++;
            $display("FAIL basic_values: got %0d outputs, required (0,8),(1,12)", got_val.size());
        end
    endtask

    task automatic test_no_input();
        load_case1();
        x0_tab[0] = 64'd3;
        a_tab[0][0] = 64'd2;
        max_delay = 1;
        start_and_load(1, 0, 3);
        finish_run("no_input");
        total++;
        if (sel_cnt[1] !== 0 || sel_cnt[2] !== 0) begin
            bad++;
            $display("FAIL no_input_sel: got B=%0d u=%0d requests, required 0 and 0", sel_cnt[1], sel_cnt[2]);
        end
        total++;
        if (got_val.size() != 3 || got_val[2] !== 64'd24) begin
            bad++;
            $display("FAIL no_input_last: got %0d outputs, required 3 ending in 24", got_val.size());
        end
    endtask

    task automatic test_stall();
        load_case1();
        max_delay = 5;
        start_and_load(2, 1, 1);
        finish_run("stall");
        max_delay = 0;
    endtask

    task automatic test_errors();
        int cfg_n [4];
        int cfg_m [4];
        int cfg_k [4];
        cfg_n = '{9, 0, 2, 2};
        cfg_m = '{1, 1, 1, 9};
        cfg_k = '{1, 1, 0, 1};
        strobe_seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            req_seen = 0;
            @(negedge clk);
            start = 1'b1;
            size_n = 64'(cfg_n[c]); size_m = 64'(cfg_m[c]); steps = 64'(cfg_k[c]);
            @(negedge clk);
            start = 1'b0;
            total++;
            if (ready !== 1'b1 || error !== 1'b1) begin
                bad++;
                $display("FAIL reject_%0d: got READY=%0b ERROR=%0b, required 1 1", c, ready, error);
            end
            @(negedge clk);
            total++;
            if (ready !== 1'b0 || error !== 1'b1 || req_seen !== 0) begin
                bad++;
                $display("FAIL reject_hold_%0d: got READY=%0b ERROR=%0b reqs=%0d, required 0 1 0", c, ready, error, req_seen);
            end
        end
        load_case1();
        start_and_load(2, 1, 1);
        finish_run("after_error");
    endtask

    task automatic test_rst_mid();
        int budget;
        load_case1();
        max_delay = 2;
        start_and_load(2, 1, 1);
        budget = 200;
        while (!(req === 1'b1 && sel === 2'd0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        total++;
        if (budget == 0) begin
            bad++;
            $display("FAIL rst_mid_reach: got no ROW_A request, required one");
        end
        rst = 1'b1;
        #1;
        total++;
        if (all_outs !== {146{1'b0}}) begin
            bad++;
            $display("FAIL rst_mid_outputs: got %0h, required 0", all_outs);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (ready_cnt !== 0) begin
            bad++;
            $display("FAIL rst_mid_ready: got %0d READY pulses, required 0", ready_cnt);
        end
        max_delay = 0;
        start_and_load(2, 1, 1);
        finish_run("rerun");
    endtask

    task automatic test_wrap();
        load_case1();
        x0_tab[0] = 64'h8000_0000_0000_0000;
        a_tab[0][0] = 64'd2;
        max_delay = 0;
        start_and_load(1, 0, 1);
        start = 1'b1;
        size_n = 64'd3; size_m = 64'd2; steps = 64'd5;
        @(negedge clk);
        start = 1'b0;
        finish_run("wrap");
        total++;
        if (got_val.size() != 1 || got_val[0] !== 64'd0) begin
            bad++;
            $display("FAIL wrap_value: got %0d outputs, required one output of 0", got_val.size());
        end
    endtask

    task automatic test_random();
        int n, m, kk;
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 8);
            m = $urandom_range(0, 8);
            kk = $urandom_range(1, 3);
            max_delay = $urandom_range(0, 3);
            for (int i = 0; i < 8; i++) begin
                x0_tab[i] = {$urandom, $urandom};
                for (int j = 0; j < 8; j++) begin
                    a_tab[i][j] = {$urandom, $urandom};
                    b_tab[i][j] = {$urandom, $urandom};
                end
                for (int k = 0; k < 4; k++) u_tab[k][i] = {$urandom, $urandom};
            end
            start_and_load(n, m, kk);
            finish_run("random");
        end
        max_delay = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_input();
        test_stall();
        test_errors();
        test_rst_mid();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
